// File: rtl/char_stream_tx_pkg.sv
// Shared constants for the character stream transmitter.
package char_stream_tx_pkg;

  localparam int unsigned CHAR_W = 7;
  localparam logic [CHAR_W-1:0] CHAR_BLANK = 7'h00;

  // Playback states
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SHOW = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  // Counter width covering the longer of the two phases; never narrower than one bit.
  function automatic int cnt_width(input int hold_ticks, input int gap_ticks);
    int m;
    m = (hold_ticks > gap_ticks) ? hold_ticks : gap_ticks;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/char_stream_tx_tick_counter.sv
// Qualified-tick counter with a runtime terminal value. done pulses on the
// counted tick that hits the terminal value; the count then wraps to zero.
module char_stream_tx_tick_counter #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [WIDTH-1:0] term,
  output logic             done
);

  logic [WIDTH-1:0] count_q;

  assign done = inc & (count_q == term);

  // Count qualified ticks, wrapping at the terminal value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr || done) begin
      count_q <= '0;
    end else if (inc) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/char_stream_tx.sv
// Character stream transmitter: buffers host-written character codes and
// replays them to the animator, each held for HOLD_TICKS frame ticks and
// followed by GAP_TICKS blank ticks.
// Optional build macro CHAR_STREAM_LOOP_EN: replay the message forever
// instead of returning to IDLE at the end.
module char_stream_tx
  import char_stream_tx_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int HOLD_TICKS = 30,
  parameter int GAP_TICKS  = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  tick60,
  input  logic                  wr_en,
  input  logic [6:0]            wr_data,
  input  logic                  clr,
  input  logic                  start,
  output logic                  char_valid,
  output logic [6:0]            char_out,
  output logic                  busy,
  output logic                  full,
  output logic [$clog2(DEPTH):0] len
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int LEN_W = IDX_W + 1;
  localparam int CNT_W = cnt_width(HOLD_TICKS, GAP_TICKS);

  logic [CHAR_W-1:0] mem [DEPTH];

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic [LEN_W-1:0] len_q;

  logic             wr_ok;
  logic [LEN_W-1:0] len_post;
  logic [LEN_W-1:0] next_idx;
  logic             cnt_clr;
  logic             cnt_inc;
  logic [CNT_W-1:0] cnt_term;
  logic             cnt_done;

  assign full     = (len_q == LEN_W'(DEPTH));
  assign wr_ok    = wr_en & ~full & ~clr;
  // End-of-message check must see a write landing in the same cycle
  assign len_post = len_q + LEN_W'(wr_ok);
  assign next_idx = LEN_W'(rd_idx_q) + LEN_W'(1);

  assign cnt_inc  = tick60 & ena & ~clr & ((state_q == SHOW) | (state_q == GAP));
  assign cnt_term = (state_q == SHOW) ? CNT_W'(HOLD_TICKS - 1) : CNT_W'(GAP_TICKS - 1);

  char_stream_tx_tick_counter #(
    .WIDTH(CNT_W)
  ) u_tick_counter (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .term (cnt_term),
    .done (cnt_done)
  );

  // Message buffer write port; contents are not reset
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[len_q[IDX_W-1:0]] <= wr_data;
    end
  end

  // Message length register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q <= '0;
    end else if (clr) begin
      len_q <= '0;
    end else if (wr_ok) begin
      len_q <= len_q + 1'b1;
    end
  end

  // Playback next-state logic; clr wins over everything, ena freezes the rest
  always_comb begin
    state_d  = state_q;
    rd_idx_d = rd_idx_q;
    cnt_clr  = 1'b0;
    if (clr) begin
      state_d  = IDLE;
      rd_idx_d = '0;
      cnt_clr  = 1'b1;
    end else if (ena) begin
      case (state_q)
        IDLE: begin
          if (start && (len_q != '0)) begin
            state_d  = SHOW;
            rd_idx_d = '0;
            cnt_clr  = 1'b1;
          end
        end
        SHOW: begin
          if (cnt_done) begin
            state_d = GAP;
          end
        end
        GAP: begin
          if (cnt_done) begin
            if (next_idx < len_post) begin
              state_d  = SHOW;
              rd_idx_d = next_idx[IDX_W-1:0];
            end else begin
`ifdef CHAR_STREAM_LOOP_EN
              state_d  = SHOW;
              rd_idx_d = '0;
`else
              state_d  = IDLE;
              rd_idx_d = '0;
`endif
            end
          end
        end
        default: begin
          state_d  = IDLE;
          rd_idx_d = '0;
        end
      endcase
    end
  end

  // Playback state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rd_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      rd_idx_q <= rd_idx_d;
    end
  end

  // Outputs follow registered state so an async reset blanks them at once
  always_comb begin
    char_valid = (state_q == SHOW);
    char_out   = char_valid ? mem[rd_idx_q] : CHAR_BLANK;
    busy       = (state_q != IDLE);
  end

  assign len = len_q;

endmodule

// File: tb/tb_char_stream_tx.sv
// Self-checking bench for char_stream_tx with a tick-count based reference model.
module tb_char_stream_tx;

  localparam int DEPTH = 16;
  localparam int H     = 3;
  localparam int G     = 2;
  localparam int P     = H + G;
  localparam int LEN_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ena = 1'b0;
  logic             tick60 = 1'b0;
  logic             wr_en = 1'b0;
  logic [6:0]       wr_data = 7'h00;
  logic             clr = 1'b0;
  logic             start = 1'b0;
  logic             char_valid;
  logic [6:0]       char_out;
  logic             busy;
  logic             full;
  logic [LEN_W-1:0] len;

  char_stream_tx #(
    .DEPTH     (DEPTH),
    .HOLD_TICKS(H),
    .GAP_TICKS (G)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .tick60    (tick60),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .clr       (clr),
    .start     (start),
    .char_valid(char_valid),
    .char_out  (char_out),
    .busy      (busy),
    .full      (full),
    .len       (len)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: stored message, playing flag, qualified ticks since start
  logic [6:0] msg[$];
  bit         playing = 1'b0;
  int         n = 0;
  bit         prev_valid = 1'b0;
  int         rises = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit         v;
    int         k;
    logic [6:0] ec;
    v = playing && ((n % P) < H);
    k = n / P;
`ifdef CHAR_STREAM_LOOP_EN
    if (msg.size() > 0) k = k % msg.size();
`endif
    ec = v ? msg[k] : 7'h00;
    check("char_valid", 32'(char_valid), 32'(v));
    check("char_out", 32'(char_out), 32'(ec));
    check("busy", 32'(busy), 32'(playing));
    check("full", 32'(full), 32'(msg.size() == DEPTH));
    check("len", 32'(len), 32'(msg.size()));
  endtask

  task automatic model_reset();
    msg.delete();
    playing = 1'b0;
    n = 0;
  endtask

  // One clock: drive at negedge, update model at posedge, check 1 time unit later
  task automatic cyc(input bit t, input bit e, input bit w, input logic [6:0] d,
                     input bit c, input bit s);
    int sz0;
    @(negedge clk);
    tick60 = t; ena = e; wr_en = w; wr_data = d; clr = c; start = s;
    @(posedge clk);
    sz0 = msg.size();
    if (c) begin
      model_reset();
    end else begin
      if (w && msg.size() < DEPTH) msg.push_back(d);
      if (e) begin
        if (!playing) begin
          if (s && sz0 > 0) begin
            playing = 1'b1;
            n = 0;
          end
        end else if (t) begin
          n++;
`ifndef CHAR_STREAM_LOOP_EN
          if (n >= msg.size() * P) playing = 1'b0;
`endif
        end
      end
    end
    #1;
    check_outputs();
    if (char_valid && !prev_valid) rises++;
    prev_valid = char_valid;
  endtask

  task automatic wr(input logic [6:0] d);
    cyc(1'b0, 1'b1, 1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic do_start();
    rises = 0;
    cyc(1'b0, 1'b1, 1'b0, 7'h00, 1'b0, 1'b1);
  endtask

  task automatic do_clr();
    cyc(1'b0, 1'b1, 1'b0, 7'h00, 1'b1, 1'b0);
  endtask

  // Advance by a number of qualified ticks with random spacing, ena drops and
  // optional appends; running out of cycle budget is itself a failure.
  task automatic run_ticks(input int ticks, input bit app);
    int got = 0;
    int c = 0;
    bit t, e, w;
    while (got < ticks && c < 20 * ticks + 20) begin
      t = ($urandom_range(0, 2) == 0);
      e = ($urandom_range(0, 7) != 0);
      w = app && ($urandom_range(0, 15) == 0);
      cyc(t, e, w, 7'($urandom_range(1, 127)), 1'b0, 1'b0);
      if (t && e) got++;
      c++;
    end
    check("tick_budget", 32'(got), 32'(ticks));
  endtask

  initial begin
    // Reset state
    model_reset();
    #3;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, 7'h00, 1'b0, 1'b0);

    // "HI" playback
    wr(7'h48);
    wr(7'h49);
    do_start();
    check("start_char", 32'(char_out), 32'h48);
    run_ticks(2 * P - 1, 1'b0);
    check("hi_rises", 32'(rises), 32'd2);
    run_ticks(1, 1'b0);
    repeat (3) cyc(1'b1, 1'b1, 1'b0, 7'h00, 1'b0, 1'b0);
    do_clr();

    // Fill past DEPTH; 17th write dropped, 16 characters played
    for (int i = 0; i < DEPTH + 1; i++) begin
      wr(7'(8'h30 + i));
      if (i == DEPTH - 1) check("full_at_depth", 32'(full), 32'd1);
    end
    check("len_after_17", 32'(len), 32'(DEPTH));
    do_start();
    run_ticks(DEPTH * P - 1, 1'b0);
    check("full_rises", 32'(rises), 32'(DEPTH));
    run_ticks(1, 1'b0);
    do_clr();

    // clr mid-SHOW, then start on an empty buffer is ignored
    wr(7'h48);
    wr(7'h49);
    do_start();
    cyc(1'b1, 1'b1, 1'b0, 7'h00, 1'b0, 1'b0);
    do_clr();
    check("clr_len", 32'(len), 32'd0);
    do_start();
    check("start_empty_busy", 32'(busy), 32'd0);
    repeat (2) cyc(1'b1, 1'b1, 1'b0, 7'h00, 1'b0, 1'b0);

    // ena low for 10 ticks during SHOW freezes the hold count
    wr(7'h48);
    wr(7'h49);
    do_start();
    cyc(1'b1, 1'b1, 1'b0, 7'h00, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 7'h00, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 7'h00, 1'b0, 1'b0);
    end
    check("ena_hold_valid", 32'(char_valid), 32'd1);
    cyc(1'b1, 1'b1, 1'b0, 7'h00, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 7'h00, 1'b0, 1'b0);
    check("ena_hold_end", 32'(char_valid), 32'd0);
    run_ticks(P + 1, 1'b0);
    do_clr();

`ifdef CHAR_STREAM_LOOP_EN
    // Three passes of a two-character message
    wr(7'h48);
    wr(7'h49);
    do_start();
    run_ticks(3 * 2 * P - 1, 1'b0);
    check("loop_rises", 32'(rises), 32'd6);
    run_ticks(1, 1'b0);
    check("loop_wrap_char", 32'(char_out), 32'h48);
    do_clr();
`endif

    // Random messages, random pacing, appends during playback
    for (int it = 0; it < 8; it++) begin
      int l;
      l = $urandom_range(1, DEPTH);
      for (int i = 0; i < l; i++) wr(7'($urandom_range(0, 127)));
      do_start();
`ifdef CHAR_STREAM_LOOP_EN
      run_ticks(l * P + $urandom_range(0, 2 * P), 1'b0);
`else
      run_ticks(l * P + 2, 1'b1);
`endif
      do_clr();
    end

    // Asynchronous reset between edges during SHOW
    wr(7'h48);
    wr(7'h49);
    do_start();
    cyc(1'b1, 1'b1, 1'b0, 7'h00, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(char_valid), 32'd0);
    check("async_rst_char", 32'(char_out), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, 7'h00, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
